// File: rtl/fetch_stage.sv
// Instruction fetch front end: holds the fetch PC, issues one memory read at a time, queues returned words for decode.
// Latency: first request in the first cycle out of reset; a word reaches out_* the cycle after its imem_resp.
// Backpressure: dec_ready=0 holds the FIFO head; no request is issued while the FIFO is full. Optional counters: FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h1eceb000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_next
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
  output logic [31:0] perf_stall
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(QUEUE_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   req_addr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [31:0]   q_inst    [QUEUE_DEPTH];
  logic [31:0]   q_pc      [QUEUE_DEPTH];
  logic [31:0]   q_pc_next [QUEUE_DEPTH];

  logic issue;
  logic push;
  logic pop;

  // Request goes out only from IDLE with room in the queue; a redirect suppresses it that cycle.
  assign issue = rst && (state == S_IDLE) && (count < DEPTH) && !redirect_valid;
  // A response arriving together with a redirect is stale and never enters the queue.
  assign push  = (state == S_WAIT) && imem_resp && !redirect_valid;
  assign pop   = out_valid && dec_ready && !redirect_valid;

  assign imem_rmask  = issue ? 4'hF : 4'h0;
  assign imem_addr   = issue ? pc : req_addr;
  assign out_valid   = (count != '0);
  assign out_inst    = q_inst[rd_ptr];
  assign out_pc      = q_pc[rd_ptr];
  assign out_pc_next = q_pc_next[rd_ptr];

  // Request channel: a redirect while waiting turns the outstanding response into one to throw away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (issue) state <= S_WAIT;
        S_WAIT:    if (imem_resp) state <= S_IDLE;
                   else if (redirect_valid) state <= S_DISCARD;
        S_DISCARD: if (imem_resp) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Architectural fetch PC and the address of the last request issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (redirect_valid) pc <= redirect_pc & ~32'd3;
      else if (push)      pc <= pc + 32'd4;
      if (issue) req_addr <= pc;
    end
  end

  // Queue pointers and occupancy; redirect empties the queue and wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Queue storage; cleared at reset so an empty head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst[i]    <= '0;
        q_pc[i]      <= '0;
        q_pc_next[i] <= '0;
      end
    end else if (push) begin
      q_inst[wr_ptr]    <= imem_rdata;
      q_pc[wr_ptr]      <= pc;
      q_pc_next[wr_ptr] <= pc + 32'd4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic        resp_dropped;
  logic [31:0] discard_inc;

  assign resp_dropped = imem_resp && ((state == S_DISCARD) || ((state == S_WAIT) && redirect_valid));
  assign discard_inc  = {31'd0, resp_dropped} + (redirect_valid ? 32'(count) : 32'd0);

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
      perf_stall     <= '0;
    end else begin
      perf_fetched   <= sat_add(perf_fetched, {31'd0, push});
      perf_discarded <= sat_add(perf_discarded, discard_inc);
      perf_stall     <= sat_add(perf_stall, {31'd0, out_valid && !dec_ready});
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
  logic [31:0] perf_stall;
`endif

  localparam logic [31:0] BASE = 32'h1eceb000;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model state: a request seen at a rising edge is answered during the next cycle.
  logic        auto_mem;
  logic        req_seen;
  logic [31:0] req_a;

  fetch_stage #(.RESET_PC(BASE), .QUEUE_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc_next    (out_pc_next)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; with auto_mem the memory answers last cycle's request.
  task automatic tick();
    req_seen = auto_mem && (imem_rmask == 4'hF);
    req_a    = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_resp  = req_seen;
      imem_rdata = req_seen ? word_at(req_a) : 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    auto_mem = 1'b0;
    imem_resp = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    dec_ready = 1'b1;
    rst = 1'b0;
    auto_mem = 1'b0;
    imem_resp = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    req_seen = 1'b0;
    req_a = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rmask", {28'd0, imem_rmask}, 32'd0);
    check("rst_addr", imem_addr, BASE);
    check("rst_inst", out_inst, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_pc_next", out_pc_next, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
`endif

    // Streaming with a 1-cycle memory: requests on alternating cycles, words in order
    rst = 1'b1;
    #1;
    auto_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("s1_rmask_issue", {28'd0, imem_rmask}, 32'hF);
      check("s1_addr", imem_addr, BASE + 32'(4 * i));
      if (i > 0) begin
        check("s1_valid", {31'd0, out_valid}, 32'd1);
        check("s1_pc", out_pc, BASE + 32'(4 * (i - 1)));
        check("s1_pc_next", out_pc_next, BASE + 32'(4 * i));
        check("s1_inst", out_inst, word_at(BASE + 32'(4 * (i - 1))));
      end
      tick();
      check("s1_rmask_wait", {28'd0, imem_rmask}, 32'd0);
      check("s1_addr_hold", imem_addr, BASE + 32'(4 * i));
      tick();
    end

    // Full queue: four words accepted, then no requests until a pop
    do_reset();
    dec_ready = 1'b0;
    auto_mem = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      check("s2_full_rmask", {28'd0, imem_rmask}, 32'd0);
      check("s2_full_head", out_pc, BASE);
      tick();
    end
    dec_ready = 1'b1;
    #1;
    check("s2_pop_cycle_rmask", {28'd0, imem_rmask}, 32'd0);
    tick();
    dec_ready = 1'b0;
    #1;
    check("s2_after_pop_rmask", {28'd0, imem_rmask}, 32'hF);
    check("s2_after_pop_addr", imem_addr, BASE + 32'h10);
    check("s2_after_pop_head", out_pc, BASE + 32'h4);
    tick();
    tick();
    check("s2_refull_rmask", {28'd0, imem_rmask}, 32'd0);
    check("s2_refull_head", out_inst, word_at(BASE + 32'h4));

    // Redirect while waiting, with two entries queued
    do_reset();
    dec_ready = 1'b0;
    auto_mem = 1'b1;
    repeat (4) tick();
    check("s3_issue_008", imem_addr, BASE + 32'h8);
    auto_mem = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = BASE + 32'h103;
    #1;
    check("s3_redirect_rmask", {28'd0, imem_rmask}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s3_flushed_valid", {31'd0, out_valid}, 32'd0);
    check("s3_discard_rmask", {28'd0, imem_rmask}, 32'd0);
    tick();
    imem_resp = 1'b1;
    imem_rdata = word_at(BASE + 32'h8);
    #1;
    check("s3_stale_rmask", {28'd0, imem_rmask}, 32'd0);
    tick();
    imem_resp = 1'b0;
    #1;
    check("s3_new_rmask", {28'd0, imem_rmask}, 32'hF);
    check("s3_new_addr", imem_addr, BASE + 32'h100);
    check("s3_stale_dropped", {31'd0, out_valid}, 32'd0);
    auto_mem = 1'b1;
    dec_ready = 1'b1;
    tick();
    tick();
    check("s3_out_valid", {31'd0, out_valid}, 32'd1);
    check("s3_out_pc", out_pc, BASE + 32'h100);
    check("s3_out_pc_next", out_pc_next, BASE + 32'h104);
    check("s3_out_inst", out_inst, word_at(BASE + 32'h100));
`ifdef FETCH_PERF_CNT_EN
    check("s3_perf_discarded", perf_discarded, 32'd3);
    check("s3_perf_stall", perf_stall, 32'd4);
    check("s3_perf_fetched", perf_fetched, 32'd3);
`endif

    // Redirect in the same cycle as the response
    do_reset();
    dec_ready = 1'b1;
    tick();
    imem_resp = 1'b1;
    imem_rdata = 32'hdead_beef;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1002;
    #1;
    check("s4_same_rmask", {28'd0, imem_rmask}, 32'd0);
    tick();
    imem_resp = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("s4_next_rmask", {28'd0, imem_rmask}, 32'hF);
    check("s4_next_addr", imem_addr, 32'h0000_1000);
    check("s4_word_dropped", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("s4_perf_discarded", perf_discarded, 32'd1);
`endif
    auto_mem = 1'b1;
    tick();
    tick();
    check("s4_out_pc", out_pc, 32'h0000_1000);
    check("s4_out_inst", out_inst, word_at(32'h0000_1000));

    // Reset while waiting, then a late response
    do_reset();
    dec_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("s5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("s5_rst_rmask", {28'd0, imem_rmask}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    imem_resp = 1'b1;
    imem_rdata = 32'hdead_beef;
    #1;
    check("s5_restart_rmask", {28'd0, imem_rmask}, 32'hF);
    check("s5_restart_addr", imem_addr, BASE);
    tick();
    imem_resp = 1'b0;
    #1;
    check("s5_late_ignored", {31'd0, out_valid}, 32'd0);
    tick();
    check("s5_still_empty", {31'd0, out_valid}, 32'd0);
    imem_resp = 1'b1;
    imem_rdata = word_at(BASE);
    tick();
    imem_resp = 1'b0;
    #1;
    check("s5_new_valid", {31'd0, out_valid}, 32'd1);
    check("s5_new_pc", out_pc, BASE);
    check("s5_new_inst", out_inst, word_at(BASE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
